cdb_writeback_arbiter: RTL and testbench

CDB_WRITEBACK_ARBITER -- requirements
Module: cdb_writeback_arbiter

---
 rtl/cdb_writeback_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cdb_writeback_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_writeback_arbiter.sv
// Common data bus writeback arbiter: three result FIFOs (ALU, MUL, DIV) feeding
// one registered broadcast port, chosen round-robin, with stall hold, flush and sticky drop flags.
module cdb_writeback_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_done,
    input  logic        mul_done,
    input  logic        div_done,
    input  logic [31:0] alu_value,
    input  logic [31:0] mul_value,
    input  logic [31:0] div_value,
    input  logic [31:0] alu_pc,
    input  logic [31:0] mul_pc,
    input  logic [31:0] div_pc,
    input  logic [7:0]  alu_paddr,
    input  logic [7:0]  mul_paddr,
    input  logic [7:0]  div_paddr,
    output logic        alu_ready,
    output logic        mul_ready,
    output logic        div_ready,
    input  logic        flush,
    input  logic        cdb_stall,
    output logic        cdb_valid,
    output logic [31:0] cdb_value,
    output logic [31:0] cdb_pc,
    output logic [7:0]  cdb_paddr,
    output logic [1:0]  cdb_src,
    output logic [2:0]  overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 72;

    logic [2:0]    done_vec;
    logic [EW-1:0] in_entry [3];
    logic [EW-1:0] head [3];
    logic [2:0]    full;
    logic [2:0]    non_empty;
    logic [2:0]    pop;
    logic [2:0]    ovf;

    logic          load;
    logic          grant_any;
    logic [1:0]    grant_src;
    logic [1:0]    start_src;
    logic [1:0]    last_reg;

    logic          cdb_valid_reg;
    logic [31:0]   cdb_value_reg;
    logic [31:0]   cdb_pc_reg;
    logic [7:0]    cdb_paddr_reg;
    logic [1:0]    cdb_src_reg;

    assign done_vec    = {div_done, mul_done, alu_done};
    assign in_entry[0] = {alu_value, alu_pc, alu_paddr};
    assign in_entry[1] = {mul_value, mul_pc, mul_paddr};
    assign in_entry[2] = {div_value, div_pc, div_paddr};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fifo
            logic [EW-1:0] mem [DEPTH];
            logic [AW-1:0] wr_ptr_reg;
            logic [AW-1:0] rd_ptr_reg;
            logic [AW:0]   count_reg;
            logic          ovf_reg;
            logic          push;

            assign full[gi]      = (count_reg == (AW+1)'(DEPTH));
            assign non_empty[gi] = (count_reg != '0);
            assign push          = done_vec[gi] && !full[gi] && !flush;
            assign head[gi]      = mem[rd_ptr_reg];
            assign ovf[gi]       = ovf_reg;

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= in_entry[gi];
                end
            end

            // Pointers wrap naturally because DEPTH is a power of two.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                    case ({push, pop[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            // Drop flag survives flush; only reset clears it.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ovf_reg <= 1'b0;
                end else if (done_vec[gi] && full[gi] && !flush) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    endgenerate

    assign alu_ready = !full[0];
    assign mul_ready = !full[1];
    assign div_ready = !full[2];
    assign overflow  = ovf;

    assign start_src = (last_reg == 2'd2) ? 2'd0 : last_reg + 2'd1;
    assign load      = !cdb_valid_reg || !cdb_stall;

    // Scan lowest priority first so the highest-priority non-empty source wins last.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] cand;
        grant_any = 1'b0;
        grant_src = 2'd0;
        sum       = 3'd0;
        cand      = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            sum  = {1'b0, start_src} + 3'(k);
            cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (non_empty[cand]) begin
                grant_any = 1'b1;
                grant_src = cand;
            end
        end
    end

    always_comb begin
        pop = 3'b000;
        if (load && grant_any && !flush) begin
            pop[grant_src] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdb_valid_reg <= 1'b0;
            cdb_value_reg <= '0;
            cdb_pc_reg    <= '0;
            cdb_paddr_reg <= '0;
            cdb_src_reg   <= '0;
            last_reg      <= 2'd2;
        end else if (flush) begin
            cdb_valid_reg <= 1'b0;
        end else if (load) begin
            if (grant_any) begin
                cdb_valid_reg <= 1'b1;
                {cdb_value_reg, cdb_pc_reg, cdb_paddr_reg} <= head[grant_src];
                cdb_src_reg   <= grant_src;
                last_reg      <= grant_src;
            end else begin
                cdb_valid_reg <= 1'b0;
            end
        end
    end

    assign cdb_valid = cdb_valid_reg;
    assign cdb_value = cdb_value_reg;
    assign cdb_pc    = cdb_pc_reg;
    assign cdb_paddr = cdb_paddr_reg;
    assign cdb_src   = cdb_src_reg;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cdb_writeback_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_done = 1'b0, mul_done = 1'b0, div_done = 1'b0;
    logic [31:0] alu_value = '0, mul_value = '0, div_value = '0;
    logic [31:0] alu_pc = '0, mul_pc = '0, div_pc = '0;
    logic [7:0]  alu_paddr = '0, mul_paddr = '0, div_paddr = '0;
    logic        alu_ready, mul_ready, div_ready;
    logic        flush = 1'b0, cdb_stall = 1'b0;
    logic        cdb_valid;
    logic [31:0] cdb_value, cdb_pc;
    logic [7:0]  cdb_paddr;
    logic [1:0]  cdb_src;
    logic [2:0]  overflow;

    int n_cmp = 0;
    int n_bad = 0;

    cdb_writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_done(alu_done), .mul_done(mul_done), .div_done(div_done),
        .alu_value(alu_value), .mul_value(mul_value), .div_value(div_value),
        .alu_pc(alu_pc), .mul_pc(mul_pc), .div_pc(div_pc),
        .alu_paddr(alu_paddr), .mul_paddr(mul_paddr), .div_paddr(div_paddr),
        .alu_ready(alu_ready), .mul_ready(mul_ready), .div_ready(div_ready),
        .flush(flush), .cdb_stall(cdb_stall),
        .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_pc(cdb_pc),
        .cdb_paddr(cdb_paddr), .cdb_src(cdb_src), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per source plus the broadcast slot.
    logic [71:0] mq [3][$];
    logic        m_valid = 1'b0;
    logic        m_new = 1'b0;
    logic [71:0] m_pay = '0;
    logic [1:0]  m_src = '0;
    int          m_last = 2;
    logic [2:0]  m_ovf = '0;
    bit          m_full [3];
    logic [2:0]  m_done;
    logic [71:0] m_ent [3];
    bit          m_found;
    int          m_s;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_valid = 1'b0; m_new = 1'b0; m_pay = '0; m_src = '0; m_last = 2; m_ovf = '0;
        end else begin
            m_new  = 1'b0;
            m_done = {div_done, mul_done, alu_done};
            m_ent[0] = {alu_value, alu_pc, alu_paddr};
            m_ent[1] = {mul_value, mul_pc, mul_paddr};
            m_ent[2] = {div_value, div_pc, div_paddr};
            for (int i = 0; i < 3; i++) m_full[i] = (mq[i].size() == DEPTH);
            if (flush) begin
                for (int i = 0; i < 3; i++) mq[i].delete();
                m_valid = 1'b0;
            end else begin
                if (!m_valid || !cdb_stall) begin
                    m_found = 1'b0;
                    for (int k = 1; k <= 3; k++) begin
                        m_s = (m_last + k) % 3;
                        if (!m_found && mq[m_s].size() > 0) begin
                            m_found = 1'b1;
                            m_pay   = mq[m_s].pop_front();
                            m_src   = 2'(m_s);
                            m_last  = m_s;
                        end
                    end
                    m_valid = m_found;
                    m_new   = m_found;
                end
                for (int i = 0; i < 3; i++) begin
                    if (m_done[i]) begin
                        if (m_full[i]) m_ovf[i] = 1'b1;
                        else mq[i].push_back(m_ent[i]);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("model_valid", 72'(cdb_valid), 72'(m_valid));
        if (m_valid) begin
            chk("model_payload", {cdb_value, cdb_pc, cdb_paddr}, m_pay);
            chk("model_src", 72'(cdb_src), 72'(m_src));
        end
        chk("model_overflow", 72'(overflow), 72'(m_ovf));
        chk("model_ready", 72'({div_ready, mul_ready, alu_ready}),
            72'({mq[2].size() < DEPTH, mq[1].size() < DEPTH, mq[0].size() < DEPTH}));
        if (m_new)
            $display("cdb src=%0d value=%h pc=%h paddr=%h", cdb_src, cdb_value, cdb_pc, cdb_paddr);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
    endtask

    task automatic set_src(input int s, input logic d, input logic [31:0] v,
                           input logic [31:0] p, input logic [7:0] a);
        case (s)
            0: begin alu_done = d; alu_value = v; alu_pc = p; alu_paddr = a; end
            1: begin mul_done = d; mul_value = v; mul_pc = p; mul_paddr = a; end
            default: begin div_done = d; div_value = v; div_pc = p; div_paddr = a; end
        endcase
    endtask

    task automatic idle();
        alu_done = 1'b0; mul_done = 1'b0; div_done = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("reset_valid", 72'(cdb_valid), 72'(0));
        chk("reset_overflow", 72'(overflow), 72'(0));
        chk("reset_ready", 72'({div_ready, mul_ready, alu_ready}), 72'(3'b111));
        reset = 1'b1;

        // Single ALU result, two-edge latency.
        set_src(0, 1'b1, 32'h0000_00AA, 32'h100, 8'h05);
        cyc();
        chk("single_e1_valid", 72'(cdb_valid), 72'(0));
        idle();
        cyc();
        chk("single_e2_valid", 72'(cdb_valid), 72'(1));
        chk("single_e2_src", 72'(cdb_src), 72'(0));
        chk("single_e2_payload", {cdb_value, cdb_pc, cdb_paddr}, {32'hAA, 32'h100, 8'h05});
        cyc();
        chk("single_e3_valid", 72'(cdb_valid), 72'(0));

        // Round-robin contention, two triples.
        do_reset();
        for (int t = 0; t < 2; t++) begin
            for (int s = 0; s < 3; s++) set_src(s, 1'b1, 32'h10 + 32'(s), 32'h0, 8'(s + 1));
            cyc();
            chk("rr_push_valid", 72'(cdb_valid), 72'(0));
            idle();
            for (int s = 0; s < 3; s++) begin
                cyc();
                chk("rr_valid", 72'(cdb_valid), 72'(1));
                chk("rr_src", 72'(cdb_src), 72'(s));
                chk("rr_value", 72'(cdb_value), 72'(32'h10 + 32'(s)));
            end
        end

        // Backpressure on a full MUL FIFO.
        do_reset();
        set_src(0, 1'b1, 32'hCAFE, 32'h44, 8'h09);
        cyc();
        idle();
        cdb_stall = 1'b1;
        set_src(1, 1'b1, 32'h200, 32'h300, 8'h20);
        cyc();
        chk("bp_load_value", 72'(cdb_value), 72'(32'hCAFE));
        for (int j = 1; j <= 4; j++) begin
            set_src(1, 1'b1, 32'h200 + 32'(j), 32'h300, 8'h20 + 8'(j));
            cyc();
            chk("bp_hold_valid", 72'(cdb_valid), 72'(1));
            chk("bp_hold_payload", {cdb_value, cdb_pc, cdb_paddr}, {32'hCAFE, 32'h44, 8'h09});
            if (j == 3) chk("bp_mul_ready_full", 72'(mul_ready), 72'(0));
        end
        chk("bp_overflow", 72'(overflow), 72'(3'b010));
        idle();
        cdb_stall = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("bp_drain_src", 72'(cdb_src), 72'(1));
            chk("bp_drain_value", 72'(cdb_value), 72'(32'h200 + 32'(j)));
        end
        cyc();
        chk("bp_drained_valid", 72'(cdb_valid), 72'(0));

        // Flush with three DIV entries queued and one on the bus.
        set_src(2, 1'b1, 32'h300, 32'h0, 8'h30);
        cyc();
        set_src(2, 1'b1, 32'h301, 32'h0, 8'h31);
        cyc();
        chk("fl_load_value", 72'(cdb_value), 72'(32'h300));
        cdb_stall = 1'b1;
        set_src(2, 1'b1, 32'h302, 32'h0, 8'h32);
        cyc();
        set_src(2, 1'b1, 32'h303, 32'h0, 8'h33);
        cyc();
        chk("fl_pre_valid", 72'(cdb_valid), 72'(1));
        flush = 1'b1;
        set_src(2, 1'b1, 32'h304, 32'h0, 8'h34);
        cyc();
        chk("fl_valid", 72'(cdb_valid), 72'(0));
        chk("fl_div_ready", 72'(div_ready), 72'(1));
        chk("fl_overflow", 72'(overflow), 72'(3'b010));
        flush = 1'b0; cdb_stall = 1'b0; idle();
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk("fl_quiet_valid", 72'(cdb_valid), 72'(0));
        end

        // Asynchronous reset between edges with buffered results.
        cdb_stall = 1'b1;
        set_src(0, 1'b1, 32'h11, 32'h1, 8'h1);
        set_src(1, 1'b1, 32'h22, 32'h2, 8'h2);
        cyc();
        cyc();
        idle();
        #3;
        reset = 1'b0;
        #1;
        chk("ar_valid", 72'(cdb_valid), 72'(0));
        chk("ar_payload", {cdb_value, cdb_pc, cdb_paddr}, 72'(0));
        chk("ar_src", 72'(cdb_src), 72'(0));
        chk("ar_overflow", 72'(overflow), 72'(0));
        chk("ar_ready", 72'({div_ready, mul_ready, alu_ready}), 72'(3'b111));
        #1;
        reset = 1'b1;
        cdb_stall = 1'b0;
        set_src(0, 1'b1, 32'h4444, 32'h500, 8'h44);
        cyc();
        chk("ar_e1_valid", 72'(cdb_valid), 72'(0));
        idle();
        cyc();
        chk("ar_e2_valid", 72'(cdb_valid), 72'(1));
        chk("ar_e2_value", 72'(cdb_value), 72'(32'h4444));

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int s = 0; s < 3; s++)
                set_src(s, $urandom_range(0, 99) < 45, $urandom, $urandom, 8'($urandom));
            cdb_stall = $urandom_range(0, 99) < 35;
            flush     = $urandom_range(0, 99) < 2;
            if (c == 800) begin
                idle();
                do_reset();
            end
            cyc();
        end
        idle();
        flush = 1'b0; cdb_stall = 1'b0;
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
